// File: rtl/cpu_axi_write_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_axi_write_master_if : AXI write-channel bundle (AW, W, B)      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface cpu_axi_write_master_if;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface
`default_nettype wire

// File: rtl/cpu_axi_write_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_axi_write_master : single-entry CPU store buffer, AXI writer   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module cpu_axi_write_master #(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  wire logic        ACLK,
  input  wire logic        ARESETn,
  input  wire logic        req_valid,
  input  wire logic [31:0] req_addr,
  input  wire logic [31:0] req_data,
  input  wire logic [3:0]  req_strb,
  output logic             req_ready,
  cpu_axi_write_master_if.master axi,
  output logic             busy,
  output logic             err,
  output logic [31:0]      err_addr,
  input  wire logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AW   = 2'd1,
    W    = 2'd2,
    B    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic        b_bad;

  assign b_bad = (axi.BRESP != 2'b00) || (axi.BID != MASTER_ID);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    // A clear is overridden by an error landing in the same cycle.
    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_data;
          strb_d  = req_strb;
          state_d = AW;
        end
      end
      AW: begin
        if (axi.AWREADY) begin
          state_d = W;
        end
      end
      W: begin
        if (axi.WREADY) begin
          state_d = B;
        end
      end
      B: begin
        if (axi.BVALID) begin
          state_d = IDLE;
          if (b_bad) begin
            err_d      = 1'b1;
            err_addr_d = addr_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      strb_q     <= 4'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Payloads are gated to zero outside their own phase.
  assign axi.AWID    = MASTER_ID;
  assign axi.AWLEN   = 4'd0;
  assign axi.AWSIZE  = 3'b010;
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = (state_q == AW);
  assign axi.AWADDR  = (state_q == AW) ? addr_q : 32'd0;
  assign axi.WVALID  = (state_q == W);
  assign axi.WLAST   = (state_q == W);
  assign axi.WDATA   = (state_q == W) ? data_q : 32'd0;
  assign axi.WSTRB   = (state_q == W) ? strb_q : 4'd0;
  assign axi.BREADY  = (state_q == B);

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule
`default_nettype wire
